// File: rtl/sxrrisc621_cache_ctrl_if.sv
// CPU request, CAM, main-memory and data-array signals of the 4-way cache controller.
// slave = the controller, master = the surrounding CPU/CAM/memory environment.
interface sxrrisc621_cache_ctrl_if;
  logic        cpu_req;
  logic [7:0]  cpu_tag;
  logic [1:0]  cpu_word;
  logic        flush;
  logic        cpu_ready;
  logic        hit;
  logic [7:0]  cam_argin;
  logic [3:0]  cam_mbits;
  logic        cam_we_n;
  logic [7:0]  cam_din;
  logic [1:0]  cam_addrs;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [3:0]  cache_addr;
  logic        cache_we;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  modport master (
    output cpu_req, cpu_tag, cpu_word, flush, cam_mbits, mem_ack,
    input  cpu_ready, hit, cam_argin, cam_we_n, cam_din, cam_addrs,
           mem_req, mem_addr, cache_addr, cache_we, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_req, cpu_tag, cpu_word, flush, cam_mbits, mem_ack,
    output cpu_ready, hit, cam_argin, cam_we_n, cam_din, cam_addrs,
           mem_req, mem_addr, cache_addr, cache_we, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/sxrrisc621_cache_ctrl.sv
// 4-way CAM-tagged cache controller: hit completes one cycle after the request edge, a miss fills 4 words
// (stalls indefinitely on mem_ack) then rewrites the tag. Optional statistics counters under CACHE_STATS_EN.
module sxrrisc621_cache_ctrl (
  input logic                    clk,
  input logic                    rst_n,
  sxrrisc621_cache_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, TAG_WR} state_t;

  state_t     state;
  logic [3:0] valid;
  logic [1:0] rr_ptr;
  logic [1:0] fill_cnt;
  logic [1:0] victim;
  logic [1:0] word_q;
  logic [7:0] tag_q;
  logic       filled;
  logic       ready_q;
  logic       hit_q;
  logic       mem_req_q;
  logic       cam_we_n_q;
  logic [3:0] addr_q;

  logic [3:0] hvec;
  logic       any_hit;
  logic [1:0] hit_way;
  logic [1:0] free_way;
  logic [1:0] victim_nxt;

  function automatic logic [1:0] low_way(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Duplicate CAM matches simply resolve to the lowest valid way.
  assign hvec       = bus.cam_mbits & valid;
  assign any_hit    = |hvec;
  assign hit_way    = low_way(hvec);
  assign free_way   = low_way(~valid);
  assign victim_nxt = (&valid) ? rr_ptr : free_way;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      rr_ptr     <= '0;
      fill_cnt   <= '0;
      victim     <= '0;
      word_q     <= '0;
      tag_q      <= '0;
      filled     <= 1'b0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      cam_we_n_q <= 1'b1;
      addr_q     <= '0;
    end else begin
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (bus.cpu_req) begin
            tag_q  <= bus.cpu_tag;
            word_q <= bus.cpu_word;
            filled <= 1'b0;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (any_hit) begin
            ready_q <= 1'b1;
            hit_q   <= ~filled;
            addr_q  <= {hit_way, word_q};
            state   <= IDLE;
          end else begin
            victim    <= victim_nxt;
            fill_cnt  <= '0;
            mem_req_q <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd3) begin
              mem_req_q  <= 1'b0;
              cam_we_n_q <= 1'b0;
              state      <= TAG_WR;
            end
          end
        end
        TAG_WR: begin
          cam_we_n_q    <= 1'b1;
          valid[victim] <= 1'b1;
          if (victim == rr_ptr) rr_ptr <= rr_ptr + 2'd1;
          filled        <= 1'b1;
          state         <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fill writes coincide with the acked memory word, so the write strobe and address follow mem_ack directly.
  assign bus.cache_we   = (state == FILL) && bus.mem_ack;
  assign bus.cache_addr = (state == FILL) ? {victim, fill_cnt} : addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {tag_q, fill_cnt};
  assign bus.cpu_ready  = ready_q;
  assign bus.hit        = hit_q;
  assign bus.cam_argin  = tag_q;
  assign bus.cam_we_n   = cam_we_n_q;
  assign bus.cam_din    = tag_q;
  assign bus.cam_addrs  = victim;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state == LOOKUP) begin
      if (any_hit && !filled && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (!any_hit && miss_cnt_q != 16'hFFFF)          miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_sxrrisc621_cache_ctrl.sv
// Bench for sxrrisc621_cache_ctrl: behavioural CAM/memory environment plus a per-access expected-cycle timeline.
module tb_sxrrisc621_cache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sxrrisc621_cache_ctrl_if bus();
  sxrrisc621_cache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       ack;
    logic       rdy;
    logic       hit;
    logic [3:0] caddr;
    logic       mreq;
    logic       we;
    logic [9:0] maddr;
    logic       camwe;
    logic [7:0] cdin;
    logic [1:0] caddrs;
  } cyc_t;

  int checks = 0;
  int failures = 0;

  // External CAM: written on the edge that ends a cam_we_n-low cycle; the bench can also plant entries.
  logic [7:0] cam_arr [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
  logic       inj = 1'b0;
  logic [1:0] inj_idx = '0;
  logic [7:0] inj_tag = '0;
  logic [3:0] mb;
  always @(posedge clk) begin
    if (bus.cam_we_n === 1'b0) cam_arr[bus.cam_addrs] <= bus.cam_din;
    if (inj) cam_arr[inj_idx] <= inj_tag;
  end
  always_comb begin
    mb = '0;
    for (int i = 0; i < 4; i++) mb[i] = (cam_arr[i] == bus.cam_argin);
  end
  assign bus.cam_mbits = mb;

  // Reference model state: what the cache must contain according to the access rules.
  cyc_t       q[$];
  logic [7:0] m_cam [4];
  logic [3:0] valid_m;
  logic [1:0] rr_m;
  int         n_hit, n_miss;

  logic [9:0] obs_maddr[$];
  logic [1:0] obs_victim;
  logic [3:0] obs_caddr;
  logic       obs_hit;
  logic [3:0] obs_mbits;
  int         obs_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic predict(input logic [7:0] tag, input logic [1:0] word, input int gap);
    cyc_t r;
    logic [3:0] hv;
    int w, g;
    q.delete();
    for (int i = 0; i < 4; i++) hv[i] = valid_m[i] && (m_cam[i] == tag);
    r = '0;
    q.push_back(r);
    w = lowest(hv);
    if (w >= 0) begin
      r = '0; r.rdy = 1'b1; r.hit = 1'b1; r.caddr = {w[1:0], word};
      q.push_back(r);
      if (n_hit < 65535) n_hit++;
    end else begin
      w = (valid_m == 4'hF) ? int'(rr_m) : lowest(~valid_m);
      if (n_miss < 65535) n_miss++;
      for (int k = 0; k < 4; k++) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        r = '0; r.mreq = 1'b1; r.maddr = {tag, k[1:0]};
        repeat (g) q.push_back(r);
        r.ack = 1'b1; r.we = 1'b1; r.caddr = {w[1:0], k[1:0]};
        q.push_back(r);
      end
      r = '0; r.camwe = 1'b1; r.cdin = tag; r.caddrs = w[1:0];
      q.push_back(r);
      r = '0;
      q.push_back(r);
      r.rdy = 1'b1; r.hit = 1'b0; r.caddr = {w[1:0], word};
      q.push_back(r);
      valid_m[w] = 1'b1;
      if (w == int'(rr_m)) rr_m = rr_m + 2'd1;
      m_cam[w] = tag;
    end
  endtask

  task automatic cmp_cycle(input cyc_t e, input logic [7:0] tag, input int i);
    cyc_t a;
    a = '0;
    a.ack   = e.ack;
    a.rdy   = bus.cpu_ready;
    a.mreq  = bus.mem_req;
    a.we    = bus.cache_we;
    a.camwe = ~bus.cam_we_n;
    if (e.rdy) a.hit = bus.hit;
    if (e.rdy || e.we) a.caddr = bus.cache_addr;
    if (e.mreq) a.maddr = bus.mem_addr;
    if (e.camwe) begin a.cdin = bus.cam_din; a.caddrs = bus.cam_addrs; end
    if (bus.cache_we === 1'b1) obs_maddr.push_back(bus.mem_addr);
    if (bus.cam_we_n === 1'b0) obs_victim = bus.cam_addrs;
    if (bus.cpu_ready === 1'b1) begin obs_caddr = bus.cache_addr; obs_hit = bus.hit; obs_lat = i; end
    checks++;
    if (a !== e || bus.cam_argin !== tag) begin
      failures++;
      $display("FAIL cycle tag=%h step=%0d actual=%h required=%h argin=%h", tag, i, a, e, bus.cam_argin);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, 32'({bus.cpu_ready, bus.hit, bus.mem_req, bus.cache_we, bus.cam_we_n,
                   bus.cache_addr, bus.cam_argin}), 32'h0000_1000);
    chk({name, "_cnt"}, {bus.hit_cnt, bus.miss_cnt}, 32'h0);
  endtask

  task automatic run_access(input logic [7:0] tag, input logic [1:0] word, input int gap, input int abort_at);
    predict(tag, word, gap);
    obs_maddr.delete();
    obs_victim = 2'bxx; obs_caddr = 4'bxxxx; obs_hit = 1'bx; obs_lat = -1;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_tag = tag; bus.cpu_word = word;
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int i = 0; i < q.size(); i++) begin
      #1;
      bus.cpu_req  = 1'b0;
      bus.cpu_tag  = 8'($urandom);
      bus.cpu_word = 2'($urandom);
      bus.mem_ack  = q[i].mreq ? q[i].ack : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i == 0) obs_mbits = bus.cam_mbits;
      cmp_cycle(q[i], tag, i);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("reset_mid_fill");
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_tag = m_cam[0];
    bus.mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.cpu_req = 1'b0;
    valid_m = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("flush_idle", 32'({bus.cpu_ready, bus.mem_req, bus.cam_we_n}), 32'h1);
    end
  endtask

  task automatic plant(input logic [1:0] idx, input logic [7:0] tag);
    @(negedge clk);
    inj = 1'b1; inj_idx = idx; inj_tag = tag;
    @(posedge clk);
    #1 inj = 1'b0;
    m_cam[idx] = tag;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_ma [4];
    int         exp_v [6];
    logic [7:0] saved [4];
    exp_ma = '{10'h0E8, 10'h0E9, 10'h0EA, 10'h0EB};
    exp_v  = '{0, 1, 2, 3, 0, 1};
    bus.cpu_req = 1'b0; bus.cpu_tag = '0; bus.cpu_word = '0; bus.flush = 1'b0; bus.mem_ack = 1'b0;
    m_cam = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    valid_m = '0; rr_m = '0; n_hit = 0; n_miss = 0;

    #1 rst_n = 1'b0;
    #12 chk_reset_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    // First miss with 3-cycle gaps between memory words.
    run_access(8'h3A, 2'd2, 3, -1);
    chk("miss_nwrites", obs_maddr.size(), 4);
    for (int k = 0; k < 4 && k < obs_maddr.size(); k++) chk("miss_mem_addr", obs_maddr[k], exp_ma[k]);
    chk("miss_victim", obs_victim, 0);
    chk("miss_cache_addr", obs_caddr, 4'h2);
    chk("miss_hit_flag", obs_hit, 0);
    chk("miss_latency", obs_lat, 19);

    run_access(8'h3A, 2'd1, 0, -1);
    chk("hit_flag", obs_hit, 1);
    chk("hit_cache_addr", obs_caddr, 4'h1);
    chk("hit_latency", obs_lat, 1);

    // Fill order: lowest invalid first, then round-robin.
    do_flush();
    for (int k = 0; k < 6; k++) begin
      run_access(8'(k + 1), 2'd0, -1, -1);
      chk("victim_order", obs_victim, exp_v[k]);
    end

    // Stale CAM match on a flushed way must still miss.
    do_flush();
    run_access(8'h01, 2'd3, 0, -1);
    do_flush();
    run_access(8'h01, 2'd0, 0, -1);
    chk("flush_mbits0", obs_mbits[0], 1);
    chk("flush_miss", obs_hit, 0);
    chk("flush_victim", obs_victim, 0);

    // Two valid ways holding the same tag resolve to the lower one.
    run_access(8'h02, 2'd0, -1, -1);
    run_access(8'h07, 2'd0, -1, -1);
    plant(2'd2, 8'h02);
    run_access(8'h02, 2'd2, -1, -1);
    chk("dup_hit", obs_hit, 1);
    chk("dup_cache_addr", obs_caddr, 4'h6);

    // Reset while waiting for fill word 2.
    saved = m_cam;
    run_access(8'h77, 2'd0, 1, 5);
    m_cam = saved; valid_m = '0; rr_m = '0; n_hit = 0; n_miss = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_access(8'h77, 2'd0, -1, -1);
    chk("post_reset_miss", obs_hit, 0);
    chk("post_reset_victim", obs_victim, 0);

    run_access(8'h78, 2'd1, -1, -1);
    run_access(8'h79, 2'd2, -1, -1);
    run_access(8'h77, 2'd3, -1, -1);
    run_access(8'h78, 2'd0, -1, -1);
    run_access(8'h79, 2'd1, -1, -1);
    run_access(8'h77, 2'd2, -1, -1);
    run_access(8'h78, 2'd3, -1, -1);
`ifdef CACHE_STATS_EN
    chk("stats_hit_cnt", bus.hit_cnt, 5);
    chk("stats_miss_cnt", bus.miss_cnt, 3);
`else
    chk("stats_hit_cnt", bus.hit_cnt, 0);
    chk("stats_miss_cnt", bus.miss_cnt, 0);
`endif

    repeat (150) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else run_access(8'h10 + 8'($urandom_range(0, 7)), 2'($urandom), -1, -1);
    end
`ifdef CACHE_STATS_EN
    chk("rand_hit_cnt", bus.hit_cnt, n_hit);
    chk("rand_miss_cnt", bus.miss_cnt, n_miss);
`else
    chk("rand_hit_cnt", bus.hit_cnt, 0);
    chk("rand_miss_cnt", bus.miss_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sxrrisc621_cache_ctrl.md
SXRRISC621_CACHE_CTRL -- requirements
Module: sxrRISC621_cache_ctrl

Interface
REQ-001 SHALL have no parameters; geometry fixed: 4 ways, 4 words/block, 8-bit tags, tag lookup via external 4-entry CAM.
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Resetn  in  1  asynchronous, active-low reset.
REQ-004 cpu_req  in  1  access request, sampled in IDLE.
REQ-005 cpu_tag  in  8  block tag of requested address.
REQ-006 cpu_word  in  2  word offset within block.
REQ-007 flush  in  1  invalidate all ways, sampled in IDLE.
REQ-008 cpu_ready  out  1  one-cycle completion pulse.
REQ-009 hit  out  1  completion was a first-lookup hit (valid only with cpu_ready).
REQ-010 cam_argin  out  8  latched request tag to CAM argument input.
REQ-011 cam_mbits  in  4  CAM match bits, combinational from cam_argin.
REQ-012 cam_we_n  out  1  CAM tag write strobe, active low.
REQ-013 cam_din  out  8  tag written to CAM.
REQ-014 cam_addrs  out  2  CAM write location (victim way).
REQ-015 mem_req  out  1  block-fill word request to main memory.
REQ-016 mem_addr  out  10  {latched tag, fill_cnt}.
REQ-017 mem_ack  in  1  memory word valid this cycle.
REQ-018 cache_addr  out  4  data-array address {way, word}.
REQ-019 cache_we  out  1  data-array write enable during fill.
REQ-020 hit_cnt / miss_cnt  out  16 each  statistics counters (see Configuration).

Function
REQ-021 States SHALL be IDLE, LOOKUP, FILL, TAG_WR; per-way valid[3:0] and round-robin pointer rr_ptr[1:0] held internally.
REQ-022 IDLE: flush=1 clears valid[3:0], stays IDLE, and ignores cpu_req that cycle; else cpu_req=1 latches cpu_tag/cpu_word, goes LOOKUP.
REQ-023 LOOKUP: hvec = cam_mbits & valid; hvec!=0 -> way = lowest set bit, cache_addr={way,word}, cpu_ready=1 for that cycle, return IDLE.
REQ-024 Hit latency SHALL be exactly one cycle after the cpu_req sampling edge; hit=1 only if no fill occurred for this request.
REQ-025 LOOKUP miss: victim = lowest invalid way, else rr_ptr; go FILL with fill_cnt=0.
REQ-026 FILL: mem_req=1 continuously; each cycle with mem_ack=1 asserts cache_we with cache_addr={victim,fill_cnt}, then increments fill_cnt; ack at fill_cnt=3 goes TAG_WR.
REQ-027 mem_ack outside FILL SHALL be ignored; fill waits indefinitely for ack.
REQ-028 TAG_WR: cam_we_n=0 for exactly one cycle with cam_din=tag, cam_addrs=victim stable; sets valid[victim]; if victim==rr_ptr, rr_ptr increments mod 4; goes LOOKUP (guaranteed hit, completes with hit=0).
REQ-029 cam_argin SHALL hold latched tag from LOOKUP entry until return to IDLE.
REQ-030 Duplicate matches (multiple hvec bits) resolved to lowest way, no error.

Reset
REQ-031 Resetn low SHALL immediately force IDLE, valid=0, rr_ptr=0, fill_cnt=0, cpu_ready=0, hit=0, mem_req=0, cache_we=0, cam_we_n=1, cache_addr=0, cam_argin=0, counters=0.
REQ-032 Reset mid-fill SHALL abandon the fill; no tag written; resumes IDLE on first edge after release.

Configuration
REQ-033 Macro CACHE_STATS_EN defined: hit_cnt increments on each hit=1 completion, miss_cnt on each LOOKUP->FILL transition, both saturate at 16'hFFFF, flush does not clear them.
REQ-034 CACHE_STATS_EN undefined: hit_cnt and miss_cnt ports present, tied to 0, no counter logic.

Verification
REQ-035 Reset, req tag 8'h3A word 2 -> miss, mem_addr 10'h0E8..0EB over 4 acks, cam_we_n low one cycle cam_addrs=0, then cpu_ready hit=0 cache_addr=4'h2.
REQ-036 Repeat tag 8'h3A word 1 -> cpu_ready one cycle after request, hit=1, cache_addr=4'h1.
REQ-037 Fill tags 01,02,03,04 then 05 -> victims 0,1,2,3 then 0; then 06 victim 1 (rr_ptr advance).
REQ-038 mem_ack gaps of 3 idle cycles between words -> fill_cnt holds, cache_we only on ack cycles.
REQ-039 flush then tag 01 -> miss despite cam_mbits[0]=1; Resetn low during FILL word 2 -> mem_req drops immediately, valid=0.
REQ-040 With CACHE_STATS_EN: 3 misses, 5 hits -> miss_cnt=3, hit_cnt=5; without macro both read 0.
